// File: rtl/nios_system_nios2_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II M-stage (DIV/DIVU).
// Constant WIDTH+1 edge latency from start to done, abortable by pipeline flush.
module nios_system_nios2_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             M_div_start,
    input  logic             M_div_signed,
    input  logic             M_div_abort,
    input  logic [WIDTH-1:0] M_div_src1,
    input  logic [WIDTH-1:0] M_div_src2,
    output logic [WIDTH-1:0] M_div_quot,
    output logic [WIDTH-1:0] M_div_rem,
    output logic             M_div_busy,
    output logic             M_div_done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] src1_orig;
    logic             q_neg;
    logic             r_neg;
    logic             dz;

    logic             sign1;
    logic             sign2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] quot_fixed;
    logic [WIDTH-1:0] rem_fixed;

    // Operand magnitudes; the most negative value maps to itself, read as unsigned.
    always_comb begin
        sign1 = M_div_signed & M_div_src1[WIDTH-1];
        sign2 = M_div_signed & M_div_src2[WIDTH-1];
        mag1  = sign1 ? (~M_div_src1 + 1'b1) : M_div_src1;
        mag2  = sign2 ? (~M_div_src2 + 1'b1) : M_div_src2;
    end

    // One restoring step on a WIDTH+1 bit remainder so the shifted-out carry survives.
    always_comb begin
        shifted  = {part_rem, dividend[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        trial_ok = ~trial[WIDTH];
    end

    always_comb begin
        quot_fixed = q_neg ? (~dividend + 1'b1) : dividend;
        rem_fixed  = r_neg ? (~part_rem + 1'b1) : part_rem;
        if (dz) begin
            quot_fixed = '1;
            rem_fixed  = src1_orig;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            part_rem   <= '0;
            dividend   <= '0;
            divisor    <= '0;
            src1_orig  <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            dz         <= 1'b0;
            M_div_quot <= '0;
            M_div_rem  <= '0;
            M_div_busy <= 1'b0;
            M_div_done <= 1'b0;
        end else begin
            M_div_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (M_div_start && !M_div_abort) begin
                        state      <= ITER;
                        count      <= CW'(WIDTH - 1);
                        part_rem   <= '0;
                        dividend   <= mag1;
                        divisor    <= mag2;
                        src1_orig  <= M_div_src1;
                        q_neg      <= sign1 ^ sign2;
                        r_neg      <= sign1;
                        dz         <= (M_div_src2 == '0);
                        M_div_busy <= 1'b1;
                    end
                end
                ITER: begin
                    if (M_div_abort) begin
                        state      <= IDLE;
                        M_div_busy <= 1'b0;
                    end else begin
                        part_rem <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                        dividend <= {dividend[WIDTH-2:0], trial_ok};
                        count    <= count - 1'b1;
                        if (count == '0) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    state      <= IDLE;
                    M_div_busy <= 1'b0;
                    if (!M_div_abort) begin
                        M_div_quot <= quot_fixed;
                        M_div_rem  <= rem_fixed;
                        M_div_done <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    M_div_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_system_nios2_div_cell.sv
// Directed self-checking bench for nios_system_nios2_div_cell.
// Each scenario task drives its own stimulus and compares against hand-computed results.
module tb_nios_system_nios2_div_cell;

    logic        clk;
    logic        reset_n;
    logic        M_div_start;
    logic        M_div_signed;
    logic        M_div_abort;
    logic [31:0] M_div_src1;
    logic [31:0] M_div_src2;
    logic [31:0] M_div_quot;
    logic [31:0] M_div_rem;
    logic        M_div_busy;
    logic        M_div_done;

    int n_checks = 0;
    int n_fail   = 0;

    nios_system_nios2_div_cell #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .M_div_start  (M_div_start),
        .M_div_signed (M_div_signed),
        .M_div_abort  (M_div_abort),
        .M_div_src1   (M_div_src1),
        .M_div_src2   (M_div_src2),
        .M_div_quot   (M_div_quot),
        .M_div_rem    (M_div_rem),
        .M_div_busy   (M_div_busy),
        .M_div_done   (M_div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Issues a one-cycle start; returns just after edge E0.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        M_div_src1   = a;
        M_div_src2   = b;
        M_div_signed = s;
        M_div_start  = 1'b1;
        tick();
        M_div_start  = 1'b0;
        M_div_src1   = 32'hDEAD_BEEF;
        M_div_src2   = 32'h0BAD_F00D;
    endtask

    // Counts edges after E0 until done, bounded; also counts busy-high cycles.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!M_div_done && lat < 100) begin
            if (M_div_busy) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] eq, input logic [31:0] er);
        int lat, bc;
        issue(a, b, s);
        wait_done(lat, bc);
        chk({name, " latency"}, lat, 33);
        chk({name, " quot"}, M_div_quot, eq);
        chk({name, " rem"}, M_div_rem, er);
        chk({name, " busy after"}, {31'd0, M_div_busy}, 0);
        if (name == "divu_basic") chk({name, " busy cycles"}, bc, 33);
        tick();
        chk({name, " done width"}, {31'd0, M_div_done}, 0);
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        M_div_start  = 1'b0;
        M_div_signed = 1'b0;
        M_div_abort  = 1'b0;
        M_div_src1   = '0;
        M_div_src2   = '0;
        repeat (3) tick();
        chk("reset quot", M_div_quot, 0);
        chk("reset rem", M_div_rem, 0);
        chk("reset busy", {31'd0, M_div_busy}, 0);
        chk("reset done", {31'd0, M_div_done}, 0);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_divu_basic();
        run_div("divu_basic", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    endtask

    task automatic test_div_signs();
        run_div("neg_by_pos", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        run_div("pos_by_neg", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2);
        run_div("neg_by_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE);
    endtask

    task automatic test_corners();
        run_div("ovf_div", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        run_div("ovf_divu", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
        run_div("max_by_one", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    endtask

    task automatic test_div_zero();
        run_div("dz_unsigned", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
        run_div("dz_signed", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
    endtask

    // Start re-pulse while busy is ignored, then a start in the done cycle is taken.
    task automatic test_back_to_back();
        int lat, bc;
        issue(32'd20, 32'd3, 1'b0);
        lat = 0;
        while (!M_div_done && lat < 100) begin
            if (lat == 10) begin
                M_div_src1  = 32'd9;
                M_div_src2  = 32'd9;
                M_div_start = 1'b1;
            end else begin
                M_div_start = 1'b0;
            end
            tick();
            lat++;
        end
        M_div_start = 1'b0;
        chk("repulse latency", lat, 33);
        chk("repulse quot", M_div_quot, 32'd6);
        chk("repulse rem", M_div_rem, 32'd2);
        issue(32'd9, 32'd9, 1'b0);
        wait_done(lat, bc);
        chk("b2b latency", lat, 33);
        chk("b2b quot", M_div_quot, 32'd1);
        chk("b2b rem", M_div_rem, 32'd0);
        tick();
    endtask

    task automatic test_abort();
        int seen_done;
        issue(32'd100, 32'd7, 1'b0);
        repeat (15) tick();
        M_div_abort = 1'b1;
        tick();
        M_div_abort = 1'b0;
        chk("abort busy", {31'd0, M_div_busy}, 0);
        seen_done = 0;
        repeat (40) begin
            if (M_div_done) seen_done++;
            tick();
        end
        chk("abort no done", seen_done, 0);
        chk("abort quot kept", M_div_quot, 32'd1);
        chk("abort rem kept", M_div_rem, 32'd0);
        M_div_abort = 1'b1;
        M_div_start = 1'b1;
        M_div_src1  = 32'd8;
        M_div_src2  = 32'd2;
        tick();
        M_div_abort = 1'b0;
        M_div_start = 1'b0;
        chk("abort beats start", {31'd0, M_div_busy}, 0);
    endtask

    task automatic test_reset_mid();
        int seen_done;
        issue(32'd100, 32'd7, 1'b0);
        repeat (20) tick();
        reset_n = 1'b0;
        #1;
        chk("midreset quot", M_div_quot, 0);
        chk("midreset rem", M_div_rem, 0);
        chk("midreset busy", {31'd0, M_div_busy}, 0);
        chk("midreset done", {31'd0, M_div_done}, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        seen_done = 0;
        repeat (40) begin
            if (M_div_done || M_div_busy) seen_done++;
            tick();
        end
        chk("midreset no activity", seen_done, 0);
        run_div("after_reset", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0);
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_div_signs();
        test_corners();
        test_div_zero();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
